// File: rtl/mem_ctrl.sv
// Byte-serial controller for the 128 KB on-board RAM: arbitrates fetch vs load/store,
// sequences little-endian byte accesses and sign/zero-extends load results.
module mem_ctrl #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [1:0]            ls_size,
  input  logic                  ls_signed,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  output logic                  ls_done,
  output logic [31:0]           ls_rdata,
  output logic                  mem_en,
  output logic                  mem_r_nw,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [7:0]            mem_d,
  input  logic [7:0]            mem_q
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  first_q, first_d;
  logic [1:0]            nm1_q, nm1_d;
  logic                  is_ls_q, is_ls_d;
  logic                  sgn_q, sgn_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           asm_q, asm_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_r_nw_q, mem_r_nw_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_d_q, mem_d_d;
  logic                  if_done_q, if_done_d;
  logic                  ls_done_q, ls_done_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           ls_rdata_q, ls_rdata_d;

  logic [ADDR_WIDTH-1:0] g_addr;
  logic [1:0]            g_nm1;
  logic                  g_we;
  logic                  g_sgn;
  logic [31:0]           g_wdata;
  logic [1:0]            lane;
  logic [1:0]            nxt;
  logic                  last;
  logic [31:0]           ext;

  // Grant decode: load/store wins over fetch whenever both are pending.
  always_comb begin
    g_addr  = if_addr;
    g_nm1   = 2'd3;
    g_we    = 1'b0;
    g_sgn   = 1'b0;
    g_wdata = '0;
    if (ls_req) begin
      g_addr  = ls_addr;
      g_we    = ls_we;
      g_sgn   = ls_signed;
      g_wdata = ls_wdata;
      case (ls_size)
        2'd0:    g_nm1 = 2'd0;
        2'd1:    g_nm1 = 2'd1;
        default: g_nm1 = 2'd3;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    nm1_d      = nm1_q;
    is_ls_d    = is_ls_q;
    sgn_d      = sgn_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    asm_d      = asm_q;
    mem_en_d   = mem_en_q;
    mem_r_nw_d = mem_r_nw_q;
    mem_a_d    = mem_a_q;
    mem_d_d    = mem_d_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    lane       = cnt_q - 2'd1;
    nxt        = cnt_q + 2'd1;
    last       = 1'b0;
    ext        = '0;

    case (state_q)
      S_IDLE: begin
        if (ls_req || if_req) begin
          addr_d   = g_addr;
          nm1_d    = g_nm1;
          is_ls_d  = ls_req;
          sgn_d    = g_sgn;
          wdata_d  = g_wdata;
          mem_a_d  = g_addr;
          mem_en_d = 1'b1;
          cnt_d    = '0;
          first_d  = 1'b1;
          if (g_we) begin
            state_d    = S_WRITE;
            mem_r_nw_d = 1'b0;
            mem_d_d    = g_wdata[7:0];
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        first_d = 1'b0;
        cnt_d   = nxt;
        // cnt wraps to 0 on the final 4-byte capture, so first_q rather than cnt==0 marks the no-data cycle.
        if (!first_q) begin
          asm_d[{lane, 3'b000} +: 8] = mem_q;
        end
        last = !first_q && (lane == nm1_q);
        if (last) begin
          case (nm1_q)
            2'd0:    ext = {{24{sgn_q & asm_d[7]}}, asm_d[7:0]};
            2'd1:    ext = {{16{sgn_q & asm_d[15]}}, asm_d[15:0]};
            default: ext = asm_d;
          endcase
          state_d  = S_DONE;
          mem_en_d = 1'b0;
          if (is_ls_q) begin
            ls_done_d  = 1'b1;
            ls_rdata_d = ext;
          end else begin
            if_done_d = 1'b1;
            if_data_d = asm_d;
          end
        end else if (cnt_q != nm1_q) begin
          mem_a_d = addr_q + ADDR_WIDTH'(nxt);
        end
      end

      S_WRITE: begin
        if (cnt_q == nm1_q) begin
          state_d    = S_DONE;
          mem_en_d   = 1'b0;
          mem_r_nw_d = 1'b1;
          ls_done_d  = 1'b1;
        end else begin
          cnt_d   = nxt;
          mem_a_d = addr_q + ADDR_WIDTH'(nxt);
          mem_d_d = wdata_q[{nxt, 3'b000} +: 8];
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      nm1_q      <= '0;
      is_ls_q    <= 1'b0;
      sgn_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      asm_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_r_nw_q <= 1'b1;
      mem_a_q    <= '0;
      mem_d_q    <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      nm1_q      <= nm1_d;
      is_ls_q    <= is_ls_d;
      sgn_q      <= sgn_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      asm_q      <= asm_d;
      mem_en_q   <= mem_en_d;
      mem_r_nw_q <= mem_r_nw_d;
      mem_a_q    <= mem_a_d;
      mem_d_q    <= mem_d_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign if_done  = if_done_q;
  assign if_data  = if_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;
  assign mem_en   = mem_en_q;
  assign mem_r_nw = mem_r_nw_q;
  assign mem_a    = mem_a_q;
  assign mem_d    = mem_d_q;

endmodule
